// File: rtl/cprv_pkg.sv
// Shared constants and types for the writeback stage: RV64I opcodes, load funct3 codes, FSM states.
// Imported by cprv_wb_unit and cprv_wb_load_align.
package cprv_pkg;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] BRANCH    = 7'b1100011;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic {IDLE, WAIT_LD} wb_state_t;

endpackage

// File: rtl/cprv_wb_load_align.sv
// Load data aligner: shifts the bus word down by the byte offset, then sign/zero-extends by funct3.
// Purely combinational, zero latency; no flow control.
module cprv_wb_load_align
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int OFFW       = $clog2(DATA_WIDTH/8)
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [OFFW-1:0]       offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      LB:  data = DATA_WIDTH'($signed(shifted[7:0]));
      LH:  data = DATA_WIDTH'($signed(shifted[15:0]));
      LW:  data = DATA_WIDTH'($signed(shifted[31:0]));
      // Doubleword only exists on a 64-bit bus; narrower builds write zero.
      LD:  data = (DATA_WIDTH == 64) ? shifted : '0;
      LBU: data = DATA_WIDTH'(shifted[7:0]);
      LHU: data = DATA_WIDTH'(shifted[15:0]);
      LWU: data = DATA_WIDTH'(shifted[31:0]);
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/cprv_wb_unit.sv
// Writeback stage driving the regfile write port; optional retire counter under CPRV_WB_INSTRET_EN.
// Write registered one cycle after accept (loads: one cycle after rvalid); ready low while a load waits.
module cprv_wb_unit
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_wb_i,
  output logic                  ready_wb_o,
  input  logic [4:0]            rd_addr_wb_i,
  input  logic                  rd_en_wb_i,
  input  logic [6:0]            opcode_wb_i,
  input  logic [2:0]            funct3_wb_i,
  input  logic [WORD_WIDTH-1:0] imm_data_wb_i,
  input  logic [DATA_WIDTH-1:0] pc_wb_i,
  input  logic [DATA_WIDTH-1:0] alu_out_wb_i,
  input  logic [DATA_WIDTH-1:0] rdata_wb_i,
  input  logic                  rvalid_wb_i,
  output logic                  rd_we_o,
  output logic [4:0]            rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
`ifdef CPRV_WB_INSTRET_EN
  ,
  output logic [63:0]           instret_o
`endif
);

  localparam int OFFW = $clog2(DATA_WIDTH/8);

  wb_state_t state, state_nxt;

  logic                  accept;
  logic                  is_load;
  logic                  writes_rd;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [OFFW-1:0]       al_off;
  logic [2:0]            al_f3;

  logic                  issue;
  logic                  issue_we;
  logic [4:0]            issue_addr;
  logic [DATA_WIDTH-1:0] issue_data;
  logic                  capture;

  logic                  pend_we;
  logic [4:0]            pend_addr;
  logic [2:0]            pend_f3;
  logic [OFFW-1:0]       pend_off;

  assign ready_wb_o = (state == IDLE);
  assign accept     = valid_wb_i && ready_wb_o;
  assign is_load    = (opcode_wb_i == LOAD);

  // A waiting load must align with its own captured offset/size, not the next instruction's.
  assign al_off = (state == WAIT_LD) ? pend_off : alu_out_wb_i[OFFW-1:0];
  assign al_f3  = (state == WAIT_LD) ? pend_f3  : funct3_wb_i;

  cprv_wb_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .rdata  (rdata_wb_i),
    .offset (al_off),
    .funct3 (al_f3),
    .data   (ld_data)
  );

  always_comb begin
    writes_rd = 1'b1;
    result    = '0;
    case (opcode_wb_i)
      OP, OP_IMM, AUIPC: result = alu_out_wb_i;
      OP_32, OP_IMM_32:  result = DATA_WIDTH'($signed(alu_out_wb_i[31:0]));
      LUI:               result = DATA_WIDTH'($signed(imm_data_wb_i));
      JAL, JALR:         result = pc_wb_i + DATA_WIDTH'(4);
      LOAD:              result = ld_data;
      default:           writes_rd = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_we   = 1'b0;
    issue_addr = rd_addr_wb_i;
    issue_data = result;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_load && !rvalid_wb_i) begin
            capture   = 1'b1;
            state_nxt = WAIT_LD;
          end else begin
            issue    = 1'b1;
            issue_we = rd_en_wb_i && writes_rd && (rd_addr_wb_i != 5'd0);
          end
        end
      end
      WAIT_LD: begin
        if (rvalid_wb_i) begin
          issue      = 1'b1;
          issue_we   = pend_we;
          issue_addr = pend_addr;
          issue_data = ld_data;
          state_nxt  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_we_o   <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
      pend_we   <= 1'b0;
      pend_addr <= '0;
      pend_f3   <= '0;
      pend_off  <= '0;
    end else begin
      state   <= state_nxt;
      rd_we_o <= issue_we;
      if (issue) begin
        rd_addr_o <= issue_addr;
        rd_data_o <= issue_data;
      end
      if (capture) begin
        pend_we   <= rd_en_wb_i && (rd_addr_wb_i != 5'd0);
        pend_addr <= rd_addr_wb_i;
        pend_f3   <= funct3_wb_i;
        pend_off  <= alu_out_wb_i[OFFW-1:0];
      end
    end
  end

`ifdef CPRV_WB_INSTRET_EN
  // Every retire counts, including instructions that never touch the regfile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_o <= '0;
    end else if (issue) begin
      instret_o <= instret_o + 64'd1;
    end
  end
`endif

endmodule
